e_muldiv: RTL and testbench
===========================

Name: e_muldiv

Overview:
- Multiply/divide unit in the Execute stage of the 5-stage MIPS pipeline.
- Consumes the forwarded rs/rt operands and the decoded MD opcode from the ID/EX register outputs.
- Holds the architectural HI/LO registers and runs multi-cycle MULT/MULTU/DIV/DIVU.
- Exposes start/busy to the hazard unit, which stalls any MD instruction in D while the unit is active.

Parameters:
- MULT_CYCLES, 5: busy cycles for MULT/MULTU (legal 1..15).
- DIV_CYCLES, 10: busy cycles for DIV/DIVU (legal 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  valid E-stage instruction; 0 after a bubble or Eclear.
- md_op  in  4  opcode: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO, 9-15 treated as NONE.
- a  in  32  forwarded rs value.
- b  in  32  forwarded rt value.
- start  out  1  combinational: req_valid & md_op in {1..4} & !busy.
- busy  out  1  registered: operation in progress.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- rdata  out  32  combinational read: hi when md_op=7, lo when md_op=8, else 0.

Behaviour:
- Reset: when reset=0 at a rising edge:
  - busy=0, hi=0, lo=0, counter=0, pending results=0, state=IDLE.
  - Applies mid-operation too; the in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1; down-counter cnt holds the remaining cycles.
- IDLE->RUN: on the edge where start=1.
  - The full result is computed from a/b in that cycle and latched into pend_hi/pend_lo.
  - cnt loads MULT_CYCLES-1 or DIV_CYCLES-1.
- RUN: cnt decrements each edge.
- RUN->IDLE: on the edge where cnt==0.
  - hi<=pend_hi, lo<=pend_lo, busy<=0.
- Timing: with start in cycle T, busy=1 in cycles T+1..T+N and 0 in T+N+1. New hi/lo are visible from T+N+1. N = MULT_CYCLES or DIV_CYCLES.
- MULT: {hi,lo} = signed a × signed b, 64-bit.
- MULTU: {hi,lo} = unsigned a × unsigned b, 64-bit.
- DIV (signed):
  - lo = quotient truncated toward zero; hi = remainder, taking the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- DIVU: unsigned quotient to lo, unsigned remainder to hi.
- Divide by zero (b=0, DIV or DIVU): the unit still goes busy for DIV_CYCLES, but hi/lo keep their previous values at completion.
- MTHI/MTLO: with req_valid=1 and busy=0, hi (resp. lo) <= a on that edge. There is no busy period.
- Ignored requests:
  - Any MD request (1..6) while busy=1 is ignored. The hazard unit guarantees none arrive; the guard exists for robustness.
  - req_valid=0 is a NONE operation regardless of md_op.
- MFHI/MFLO: rdata is combinational from the current hi/lo and never changes state. A read while busy returns the pre-operation value; stalling is the hazard unit's job.
- Same edge as completion: a request on the completion edge sees busy=1 and is ignored. The next operation may start at T+N+1.
- No interaction with Eclear beyond req_valid. An already-started operation is never cancelled, only reset aborts it.

Test Plan:
- Reset: reset=0 for 2 cycles after writing hi/lo -> hi=lo=0, busy=0. Drive reset=0 during cycle 3 of a DIV -> busy=0 next cycle, hi=lo=0, no late commit.
- MULT a=0xFFFFFFFE(-2) b=3 at T, MULT_CYCLES=5 -> start=1 at T; busy=1 in T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA from T+6. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV a=0xFFFFFFF9(-7) b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Divide by zero: preload hi=0x11 and lo=0x22 via MTHI/MTLO, then DIVU b=0 -> busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- Request while busy: MULT starts, then MTLO a=0x55 and a second MULT arrive mid-run -> both are ignored; lo equals the first product and busy drops exactly MULT_CYCLES after the first start.
- MFHI/MFLO and back-to-back: MTHI 0xABCD then md_op=7 -> rdata=0xABCD in the following cycle. A MULT issued on the cycle busy falls starts immediately (start=1), with no idle gap.

Source files
------------

// File: rtl/e_muldiv.sv
// Multiply/divide unit for the Execute stage: owns HI/LO and runs multi-cycle
// MULT/MULTU/DIV/DIVU, committing the precomputed result when the countdown ends.
module e_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_we;

    logic        is_mult, is_div, b_zero;
    logic [63:0] smul, umul;
    logic [31:0] b_safe, a_mag, b_mag, b_mag_safe;
    logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;
    logic [31:0] res_hi, res_lo;

    assign is_mult = (md_op == 4'd1) || (md_op == 4'd2);
    assign is_div  = (md_op == 4'd3) || (md_op == 4'd4);
    assign b_zero  = (b == 32'd0);

    assign busy  = (state == RUN);
    assign start = req_valid && (is_mult || is_div) && !busy;
    assign rdata = (md_op == 4'd7) ? hi : ((md_op == 4'd8) ? lo : 32'd0);

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign smul       = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign umul       = {32'd0, a} * {32'd0, b};
    assign b_safe     = b_zero ? 32'd1 : b;
    assign uq         = a / b_safe;
    assign ur         = a % b_safe;
    assign a_mag      = a[31] ? -a : a;
    assign b_mag      = b[31] ? -b : b;
    assign b_mag_safe = b_zero ? 32'd1 : b_mag;
    assign sq_mag     = a_mag / b_mag_safe;
    assign sr_mag     = a_mag % b_mag_safe;
    assign sq         = (a[31] ^ b[31]) ? -sq_mag : sq_mag;
    assign sr         = a[31] ? -sr_mag : sr_mag;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (md_op)
            4'd1:    {res_hi, res_lo} = smul;
            4'd2:    {res_hi, res_lo} = umul;
            4'd3:    begin res_hi = sr; res_lo = sq; end
            4'd4:    begin res_hi = ur; res_lo = uq; end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        if (state == IDLE) begin
            if (start) state_next = RUN;
        end else begin
            if (cnt == 4'd0) state_next = IDLE;
        end
    end

    // A divide by zero still runs the full countdown but never commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE) begin
                if (start) begin
                    cnt     <= is_mult ? MULT_LOAD : DIV_LOAD;
                    pend_hi <= res_hi;
                    pend_lo <= res_lo;
                    pend_we <= !(is_div && b_zero);
                end else if (req_valid && md_op == 4'd5) begin
                    hi <= a;
                end else if (req_valid && md_op == 4'd6) begin
                    lo <= a;
                end
            end else begin
                if (cnt == 4'd0) begin
                    if (pend_we) begin
                        hi <= pend_hi;
                        lo <= pend_lo;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_e_muldiv.sv
// Directed bench for e_muldiv: hand-computed HI/LO results, busy timing,
// ignored requests, divide by zero and reset aborts.
module tb_e_muldiv;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [3:0]  md_op;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] hi, lo, rdata;

    int compare_count  = 0;
    int mismatch_count = 0;

    e_muldiv #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .md_op     (md_op),
        .a         (a),
        .b         (b),
        .start     (start),
        .busy      (busy),
        .hi        (hi),
        .lo        (lo),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change on the falling edge; checks happen 1 ns later, well before the rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] op,
                                 input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        req_valid = v;
        md_op     = op;
        a         = va;
        b         = vb;
        #1;
    endtask

    task automatic runOp(input string tag, input logic [3:0] op,
                         input logic [31:0] va, input logic [31:0] vb, input int n);
        applyStimulus(1'b1, op, va, vb);
        checkOutput({tag, "_start"}, {31'd0, start}, 32'd1);
        for (int k = 1; k <= n; k++) begin
            applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
            checkOutput($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
        end
    endtask

    task automatic checkDone(input string tag, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input logic v, input logic [3:0] op,
                             input logic [31:0] va, input logic [31:0] vb,
                             input logic exp_start);
        applyStimulus(v, op, va, vb);
        checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_hi"}, hi, exp_hi);
        checkOutput({tag, "_lo"}, lo, exp_lo);
        checkOutput({tag, "_nxtstart"}, {31'd0, start}, {31'd0, exp_start});
    endtask

    task automatic simpleOp(input string tag, input logic [3:0] op,
                            input logic [31:0] va, input logic [31:0] vb, input int n,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        runOp(tag, op, va, vb, n);
        checkDone(tag, exp_hi, exp_lo, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0; req_valid = 1'b0; md_op = OP_NONE; a = 32'd0; b = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        simpleOp("mult",   OP_MULT,  32'hFFFFFFFE, 32'd3, MULT_N, 32'hFFFFFFFF, 32'hFFFFFFFA);
        simpleOp("multu",  OP_MULTU, 32'hFFFFFFFE, 32'd3, MULT_N, 32'h00000002, 32'hFFFFFFFA);
        simpleOp("div",    OP_DIV,   32'hFFFFFFF9, 32'd2, DIV_N,  32'hFFFFFFFF, 32'hFFFFFFFD);
        simpleOp("divu",   OP_DIVU,  32'd7,        32'd2, DIV_N,  32'd1,        32'd3);
        simpleOp("divovf", OP_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_N, 32'd0, 32'h80000000);
        simpleOp("divneg", OP_DIV,   32'd7,        32'hFFFFFFFE, DIV_N, 32'd1,  32'hFFFFFFFD);

        // Divide by zero leaves the preloaded HI/LO untouched.
        applyStimulus(1'b1, OP_MTHI, 32'h11, 32'd0);
        applyStimulus(1'b1, OP_MTLO, 32'h22, 32'd0);
        checkOutput("mthi_hi", hi, 32'h11);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("mtlo_lo", lo, 32'h22);
        simpleOp("divu0", OP_DIVU, 32'd1234, 32'd0, DIV_N, 32'h11, 32'h22);
        simpleOp("div0",  OP_DIV,  32'hFFFFFFF0, 32'd0, DIV_N, 32'h11, 32'h22);

        // Requests arriving mid-run are dropped and do not extend busy.
        applyStimulus(1'b1, OP_MULT, 32'h1234, 32'h10);
        checkOutput("ign_start", {31'd0, start}, 32'd1);
        applyStimulus(1'b1, OP_MTLO, 32'h55, 32'd0);
        checkOutput("ign_mtlo_start", {31'd0, start}, 32'd0);
        checkOutput("ign_busy1", {31'd0, busy}, 32'd1);
        applyStimulus(1'b1, OP_MULT, 32'd7, 32'd9);
        checkOutput("ign_mult_start", {31'd0, start}, 32'd0);
        checkOutput("ign_lo_mid", lo, 32'h22);
        for (int k = 3; k <= MULT_N; k++) begin
            applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
            checkOutput($sformatf("ign_busy%0d", k), {31'd0, busy}, 32'd1);
        end
        checkDone("ign", 32'd0, 32'h00012340, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);

        // Back-to-back: next MULT issued in the very cycle busy drops.
        runOp("b2b_a", OP_MULT, 32'd5, 32'd6, MULT_N);
        checkDone("b2b_a", 32'd0, 32'd30, 1'b1, OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        for (int k = 1; k <= MULT_N; k++) begin
            applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
            checkOutput($sformatf("b2b_b_busy%0d", k), {31'd0, busy}, 32'd1);
        end
        checkDone("b2b_b", 32'd0, 32'd1, 1'b0, OP_NONE, 32'd0, 32'd0, 1'b0);

        applyStimulus(1'b1, OP_MTHI, 32'hABCD, 32'd0);
        applyStimulus(1'b1, OP_MFHI, 32'd0, 32'd0);
        checkOutput("mfhi", rdata, 32'hABCD);
        applyStimulus(1'b1, OP_MTLO, 32'h1357, 32'd0);
        applyStimulus(1'b1, OP_MFLO, 32'd0, 32'd0);
        checkOutput("mflo", rdata, 32'h1357);
        checkOutput("mflo_hi_kept", hi, 32'hABCD);
        applyStimulus(1'b1, OP_NONE, 32'd0, 32'd0);
        checkOutput("rdata_none", rdata, 32'd0);

        // Two-cycle reset clears written HI/LO.
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("rst2_hi", hi, 32'd0);
        checkOutput("rst2_lo", lo, 32'd0);
        checkOutput("rst2_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;

        // Reset during the third busy cycle of a DIV aborts it without a late commit.
        applyStimulus(1'b1, OP_DIV, 32'd100, 32'd7);
        checkOutput("abort_start", {31'd0, start}, 32'd1);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (DIV_N + 2) applyStimulus(1'b0, OP_NONE, 32'd0, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        checkOutput("abort_busy_late", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
